// File: rtl/tile_sequencer.sv
// tile_sequencer
//
// Initiator side of the tile turn-passing protocol for one chain of Sudoku
// tiles. Exactly one tile holds the turn at a time. The chain is walked forward
// when a tile reports it placed a value, and backward when a tile reports it
// ran out of candidates. The block reports whole-chain success or failure and
// counts the grants it has issued, which is useful when diagnosing backtracking.
//
// Parameters
//   LEN      number of tiles in the chain (>= 2)
//   TIMEOUT  cycles to wait for a tile response before giving up (>= 2)
//   STEPW    width of the grant counter
//
// Ports
//   clock    rising-edge clock
//   reset    asynchronous active-high reset
//   start    begin a new walk at tile 0 (sampled in IDLE/DONE/FAIL)
//   abort    return to IDLE from any other state
//   myturn   one-hot turn grant, bit i drives tile i
//   passfwd  bit i pulses when tile i has placed a value
//   passbak  bit i pulses when tile i has exhausted its candidates
//   index    current tile index
//   busy     a walk is in progress (GRANT/WAIT)
//   done     whole chain solved
//   failed   chain could not be solved, or a tile stopped responding
//   timeout  qualifies failed: the failure came from the response timer
//   steps    grants issued since the last start, saturating

`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module tile_sequencer #(
    parameter int LEN     = `GRID_LEN,
    parameter int TIMEOUT = 1024,
    parameter int STEPW   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    output logic [LEN-1:0]          myturn,
    input  logic [LEN-1:0]          passfwd,
    input  logic [LEN-1:0]          passbak,
    output logic [$clog2(LEN)-1:0]  index,
    output logic                    busy,
    output logic                    done,
    output logic                    failed,
    output logic                    timeout,
    output logic [STEPW-1:0]        steps
);

    localparam int IW = $clog2(LEN);
    localparam int WW = $clog2(TIMEOUT);

    localparam logic [IW-1:0]  LAST_INDEX = IW'(LEN - 1);
    localparam logic [WW-1:0]  LAST_WAIT  = WW'(TIMEOUT - 1);
    localparam logic [LEN-1:0] TURN_ZERO  = LEN'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     index_q, index_d;
    logic [STEPW-1:0]  steps_q, steps_d;
    logic [WW-1:0]     wait_q,  wait_d;
    logic              tflag_q, tflag_d;

    logic              sel_fwd;
    logic              sel_bak;

    // Only the response lines of the tile currently holding the turn matter;
    // stray pulses from other tiles are deliberately dropped here.
    always_comb begin
        sel_fwd = passfwd[index_q];
        sel_bak = passbak[index_q];
    end

    // State and datapath registers. Reset returns everything to IDLE with a
    // zero index and count, which also pulls myturn low without a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            index_q <= '0;
            steps_q <= '0;
            wait_q  <= '0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            steps_q <= steps_d;
            wait_q  <= wait_d;
            tflag_q <= tflag_d;
        end
    end

    // Next-state logic. Abort is checked before anything else so it beats
    // both start and tile responses. In WAIT, an exhausted tile beats a
    // placing tile when both fire together: stepping back is always safe
    // because the tile rescans its candidates on its next turn anyway.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        steps_d = steps_q;
        wait_d  = wait_q;
        tflag_d = tflag_q;

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            tflag_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state_d = S_GRANT;
                        index_d = '0;
                        steps_d = '0;
                        wait_d  = '0;
                        tflag_d = 1'b0;
                    end
                end

                S_GRANT: begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                    if (!(&steps_q)) begin
                        steps_d = steps_q + STEPW'(1);
                    end
                end

                S_WAIT: begin
                    if (sel_bak) begin
                        if (index_q == '0) begin
                            state_d = S_FAIL;
                            tflag_d = 1'b0;
                        end else begin
                            index_d = index_q - IW'(1);
                            state_d = S_GRANT;
                        end
                    end else if (sel_fwd) begin
                        if (index_q == LAST_INDEX) begin
                            state_d = S_DONE;
                        end else begin
                            index_d = index_q + IW'(1);
                            state_d = S_GRANT;
                        end
                    end else if (wait_q == LAST_WAIT) begin
                        state_d = S_FAIL;
                        tflag_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded purely from registered state so tiles never see a
    // combinational path from their own pass lines back to myturn.
    always_comb begin
        myturn  = (state_q == S_GRANT) ? (TURN_ZERO << index_q) : '0;
        index   = index_q;
        steps   = steps_q;
        busy    = (state_q == S_GRANT) || (state_q == S_WAIT);
        done    = (state_q == S_DONE);
        failed  = (state_q == S_FAIL);
        timeout = (state_q == S_FAIL) && tflag_q;
    end

endmodule

// File: tb/tb_tile_sequencer.sv
// tb_tile_sequencer
//
// Directed bench for tile_sequencer with a nine-tile chain, a short response
// timer and a narrow grant counter so saturation is reachable. A behavioural
// chain model tracks who holds the turn and how the walk ended; a compare
// process checks every output against it on each falling edge. Directed
// sequences add hand-computed literal expectations at key points.

module tb_tile_sequencer;

    localparam int LEN     = 9;
    localparam int TIMEOUT = 8;
    localparam int STEPW   = 4;
    localparam int IW      = $clog2(LEN);
    localparam int SMAX    = (1 << STEPW) - 1;

    logic             clock   = 1'b0;
    logic             reset   = 1'b0;
    logic             start   = 1'b0;
    logic             abort   = 1'b0;
    logic [LEN-1:0]   passfwd = '0;
    logic [LEN-1:0]   passbak = '0;
    logic [LEN-1:0]   myturn;
    logic [IW-1:0]    index;
    logic             busy;
    logic             done;
    logic             failed;
    logic             timeout;
    logic [STEPW-1:0] steps;

    int checks   = 0;
    int failures = 0;

    tile_sequencer #(
        .LEN     (LEN),
        .TIMEOUT (TIMEOUT),
        .STEPW   (STEPW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .myturn  (myturn),
        .passfwd (passfwd),
        .passbak (passbak),
        .index   (index),
        .busy    (busy),
        .done    (done),
        .failed  (failed),
        .timeout (timeout),
        .steps   (steps)
    );

    always #5 clock = ~clock;

    // Chain model: which tile owns the turn, whether it is in its grant cycle,
    // how long it has been silent, and how the last walk ended
    // (0 = no outcome, 1 = solved, 2 = failed).
    bit m_walking  = 1'b0;
    bit m_granting = 1'b0;
    bit m_bytimer  = 1'b0;
    int m_tile     = 0;
    int m_grants   = 0;
    int m_silent   = 0;
    int m_outcome  = 0;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_walking = 0; m_granting = 0; m_bytimer = 0;
                m_tile = 0; m_grants = 0; m_silent = 0; m_outcome = 0;
            end else if (abort && (m_walking || m_outcome != 0)) begin
                m_walking = 0; m_granting = 0; m_outcome = 0; m_bytimer = 0;
            end else if (!m_walking) begin
                if (start) begin
                    m_walking = 1; m_granting = 1; m_tile = 0; m_grants = 0;
                    m_outcome = 0; m_bytimer = 0;
                end
            end else if (m_granting) begin
                m_granting = 0;
                m_silent   = 0;
                if (m_grants < SMAX) m_grants++;
            end else if (passbak[m_tile]) begin
                if (m_tile == 0) begin
                    m_walking = 0; m_outcome = 2; m_bytimer = 0;
                end else begin
                    m_tile--; m_granting = 1;
                end
            end else if (passfwd[m_tile]) begin
                if (m_tile == LEN - 1) begin
                    m_walking = 0; m_outcome = 1;
                end else begin
                    m_tile++; m_granting = 1;
                end
            end else begin
                m_silent++;
                if (m_silent == TIMEOUT) begin
                    m_walking = 0; m_outcome = 2; m_bytimer = 1;
                end
            end
        end
    end

    // Every-cycle comparison against the chain model.
    initial begin
        logic [LEN-1:0] exp_turn;
        forever begin
            @(negedge clock);
            exp_turn = '0;
            if (m_granting) exp_turn[m_tile] = 1'b1;
            check_output("myturn",  32'(myturn),  32'(exp_turn));
            check_output("index",   32'(index),   32'(m_tile));
            check_output("steps",   32'(steps),   32'(m_grants));
            check_output("busy",    32'(busy),    32'(m_walking));
            check_output("done",    32'(done),    32'(m_outcome == 1));
            check_output("failed",  32'(failed),  32'(m_outcome == 2));
            check_output("timeout", 32'(timeout), 32'(m_outcome == 2 && m_bytimer));
        end
    end

    // Waits (bounded) until the given tile holds the turn, checking the
    // current cycle first so a grant already visible is not missed.
    task automatic wait_turn(input int tile);
        for (int n = 0; n < 60; n++) begin
            if (myturn[tile] === 1'b1) break;
            @(negedge clock);
        end
        check_output($sformatf("grant_%0d_seen", tile), 32'(myturn[tile]), 32'd1);
    endtask

    task automatic pulse(input logic [LEN-1:0] fwd, input logic [LEN-1:0] bak);
        @(negedge clock);
        passfwd = fwd;
        passbak = bak;
        @(negedge clock);
        passfwd = '0;
        passbak = '0;
    endtask

    // Plays one tile: wait for its turn, answer one cycle later.
    task automatic apply_stimulus(input int tile, input bit fwd, input bit bak);
        logic [LEN-1:0] hot;
        hot = '0;
        hot[tile] = 1'b1;
        wait_turn(tile);
        pulse(fwd ? hot : '0, bak ? hot : '0);
    endtask

    task automatic start_walk();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset in the middle of a WAIT at tile 3.
        start_walk();
        for (int t = 0; t < 3; t++) apply_stimulus(t, 1'b1, 1'b0);
        wait_turn(3);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check_output("rst_myturn", 32'(myturn), 32'd0);
        check_output("rst_index",  32'(index),  32'd0);
        check_output("rst_busy",   32'(busy),   32'd0);
        check_output("rst_steps",  32'(steps),  32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check_output("idle_myturn", 32'(myturn), 32'd0);
        end

        // Straight run through all nine tiles.
        start_walk();
        for (int t = 0; t < LEN - 1; t++) apply_stimulus(t, 1'b1, 1'b0);
        wait_turn(LEN - 1);
        @(negedge clock);
        passfwd[LEN-1] = 1'b1;
        check_output("done_early", 32'(done), 32'd0);
        @(negedge clock);
        passfwd = '0;
        check_output("done_after_turn8", 32'(done),  32'd1);
        check_output("straight_steps",   32'(steps), 32'd9);
        check_output("straight_index",   32'(index), 32'd8);

        // Backtrack at tile 4: grants 0,1,2,3,4,3,4,5,6,7,8 = eleven.
        start_walk();
        for (int t = 0; t < 4; t++) apply_stimulus(t, 1'b1, 1'b0);
        apply_stimulus(4, 1'b0, 1'b1);
        for (int t = 3; t < LEN; t++) apply_stimulus(t, 1'b1, 1'b0);
        check_output("backtrack_done",  32'(done),  32'd1);
        check_output("backtrack_steps", 32'(steps), 32'd11);

        // Tile 0 exhausted: the whole chain fails without the timer.
        start_walk();
        apply_stimulus(0, 1'b0, 1'b1);
        check_output("chain_failed",  32'(failed),  32'd1);
        check_output("chain_timeout", 32'(timeout), 32'd0);
        check_output("chain_index",   32'(index),   32'd0);
        check_output("chain_steps",   32'(steps),   32'd1);

        // Stray pulse, simultaneous pulses, then silence until the timer fires.
        start_walk();
        apply_stimulus(0, 1'b1, 1'b0);
        apply_stimulus(1, 1'b1, 1'b0);
        wait_turn(2);
        pulse(LEN'(1) << 7, '0);
        check_output("stray_index", 32'(index), 32'd2);
        pulse(LEN'(1) << 2, LEN'(1) << 2);
        check_output("both_turn", 32'(myturn), 32'h002);
        apply_stimulus(1, 1'b1, 1'b0);
        wait_turn(2);
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            @(negedge clock);
            if (k == TIMEOUT) check_output("tmo_early", 32'(failed), 32'd0);
        end
        check_output("tmo_failed",  32'(failed),  32'd1);
        check_output("tmo_flag",    32'(timeout), 32'd1);
        check_output("tmo_steps",   32'(steps),   32'd5);

        // Abort at tile 5, then restart.
        start_walk();
        for (int t = 0; t < 5; t++) apply_stimulus(t, 1'b1, 1'b0);
        wait_turn(5);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check_output("abort_busy",   32'(busy),   32'd0);
        check_output("abort_myturn", 32'(myturn), 32'd0);
        check_output("abort_index",  32'(index),  32'd5);
        check_output("abort_steps",  32'(steps),  32'd6);
        start_walk();
        check_output("restart_turn",  32'(myturn), 32'd1);
        @(negedge clock);
        check_output("restart_steps", 32'(steps),  32'd1);

        // Abort beats start and a pass pulse in the same cycle.
        abort = 1'b1;
        start = 1'b1;
        passfwd[0] = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        start = 1'b0;
        passfwd = '0;
        check_output("abort_prio_busy",  32'(busy),  32'd0);
        check_output("abort_prio_index", 32'(index), 32'd0);

        // Bounce between tiles 0 and 1 until the narrow counter saturates.
        start_walk();
        for (int r = 0; r < 8; r++) begin
            apply_stimulus(0, 1'b1, 1'b0);
            apply_stimulus(1, 1'b0, 1'b1);
        end
        wait_turn(0);
        @(negedge clock);
        check_output("sat_steps", 32'(steps), 32'(SMAX));
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        repeat (3) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
